// File: rtl/res1_nibble_packer.sv
// RES1 nibble packer: gathers 4-bit RES1 lanes into wide words
// and queues them in a small FWFT FIFO with a sticky overflow flag.
module res1_nibble_packer #(
  parameter int NIBBLES_PER_WORD = 8,
  parameter int FIFO_DEPTH       = 4,
  localparam int W  = 4 * NIBBLES_PER_WORD,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          UserCLK,
  input  logic          resetn,
  input  logic [3:0]    nib_in,
  input  logic          nib_valid,
  input  logic          flush,
  output logic [W-1:0]  word_out,
  output logic          word_partial,
  output logic          word_valid,
  input  logic          word_ready,
  output logic [LW-1:0] fifo_level,
  output logic          overflow,
  input  logic          overflow_clr
);

  localparam int NCW = (NIBBLES_PER_WORD > 1) ?
                       $clog2(NIBBLES_PER_WORD) : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);

  logic [NCW-1:0]        nc_q, nc_d;
  logic [W-1:0]          pack_q, pack_d, pack_nx;
  logic [W-1:0]          mem_q [FIFO_DEPTH];
  logic [W-1:0]          mem_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] part_q, part_d;
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  ovf_q, ovf_d;

  logic last, push, pop, full, do_push, drop;

  always_comb begin
    pack_nx = pack_q;
    for (int i = 0; i < NIBBLES_PER_WORD; i++) begin
      if (nib_valid && nc_q == NCW'(i)) begin
        pack_nx[4*i +: 4] = nib_in;
      end
    end
    last = nib_valid && (nc_q == NCW'(NIBBLES_PER_WORD - 1));
    // a flush-qualified nibble that completes the word is one full push
    push = last || (flush && (nc_q != '0 || nib_valid));
    if (push) begin
      pack_d = '0;
      nc_d   = '0;
    end else begin
      pack_d = pack_nx;
      nc_d   = nib_valid ? nc_q + NCW'(1) : nc_q;
    end
  end

  always_comb begin
    full    = (level_q == LW'(FIFO_DEPTH));
    pop     = (level_q != '0) && word_ready;
    do_push = push && (!full || pop);
    drop    = push && full && !pop;
    mem_d   = mem_q;
    part_d  = part_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (do_push) begin
      mem_d[wptr_q]  = pack_nx;
      part_d[wptr_q] = !last;
      wptr_d         = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end
    unique case ({do_push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (drop) begin
      ovf_d = 1'b1;
    end else if (overflow_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      nc_q    <= '0;
      pack_q  <= '0;
      mem_q   <= '{default: '0};
      part_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      nc_q    <= nc_d;
      pack_q  <= pack_d;
      mem_q   <= mem_d;
      part_q  <= part_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  assign word_out     = mem_q[rptr_q];
  assign word_partial = part_q[rptr_q];
  assign word_valid   = (level_q != '0);
  assign fifo_level   = level_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_res1_nibble_packer.sv
// Directed bench for res1_nibble_packer: packing, flush, FIFO
// full/overflow, simultaneous push/pop and asynchronous reset.
module tb_res1_nibble_packer;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  nib_in;
  logic        nib_valid;
  logic        flush;
  logic [31:0] word_out;
  logic        word_partial;
  logic        word_valid;
  logic        word_ready;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        overflow_clr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  res1_nibble_packer dut (
    .UserCLK      (clk),
    .resetn       (resetn),
    .nib_in       (nib_in),
    .nib_valid    (nib_valid),
    .flush        (flush),
    .word_out     (word_out),
    .word_partial (word_partial),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  // stimulus helpers: inputs change on negedge, outputs read on negedge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic nib(input logic [3:0] v, input logic f);
    nib_in    = v;
    nib_valid = 1'b1;
    flush     = f;
    step();
    nib_valid = 1'b0;
    flush     = 1'b0;
    nib_in    = 4'h0;
  endtask

  task automatic fill_word(input logic [3:0] v);
    for (int i = 0; i < 8; i++) nib(v, 1'b0);
  endtask

  task automatic pop_one();
    word_ready = 1'b1;
    step();
    word_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    nib_in = 4'h0;
    nib_valid = 1'b0;
    flush = 1'b0;
    word_ready = 1'b0;
    overflow_clr = 1'b0;
    step();
    step();
    checks++;
    if (word_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b expected 0", word_valid);
    end
    checks++;
    if (fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL reset_level: got %0d expected 0", fifo_level);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: got %b expected 0", overflow);
    end
    checks++;
    if (word_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_word: got %h expected 00000000", word_out);
    end
    checks++;
    if (word_partial !== 1'b0) begin
      errors++;
      $display("FAIL reset_partial: got %b expected 0", word_partial);
    end
    resetn = 1'b1;
    step();
    pop_one();
    checks++;
    if (fifo_level !== 3'd0 || word_valid !== 1'b0) begin
      errors++;
      $display("FAIL pop_empty: got level %0d valid %b expected 0 0",
               fifo_level, word_valid);
    end
  endtask

  task automatic test_full_word();
    for (int i = 1; i <= 7; i++) nib(4'(i), 1'b0);
    checks++;
    if (word_valid !== 1'b0) begin
      errors++;
      $display("FAIL early_valid: got %b expected 0", word_valid);
    end
    nib(4'h8, 1'b0);
    checks++;
    if (word_valid !== 1'b1 || fifo_level !== 3'd1) begin
      errors++;
      $display("FAIL word1_valid: got valid %b level %0d expected 1 1",
               word_valid, fifo_level);
    end
    checks++;
    if (word_out !== 32'h87654321 || word_partial !== 1'b0) begin
      errors++;
      $display("FAIL word1_data: got %h p=%b expected 87654321 p=0",
               word_out, word_partial);
    end
    pop_one();
    checks++;
    if (fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL word1_pop: got %0d expected 0", fifo_level);
    end
  endtask

  task automatic test_flush();
    nib(4'hA, 1'b0);
    nib(4'hB, 1'b0);
    nib(4'hC, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (word_out !== 32'h00000CBA || word_partial !== 1'b1) begin
      errors++;
      $display("FAIL flush_data: got %h p=%b expected 00000cba p=1",
               word_out, word_partial);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (fifo_level !== 3'd1) begin
      errors++;
      $display("FAIL flush_noop: got %0d expected 1", fifo_level);
    end
    pop_one();
  endtask

  task automatic test_overflow();
    fill_word(4'h1);
    fill_word(4'h2);
    fill_word(4'h3);
    fill_word(4'h4);
    checks++;
    if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_level: got %0d ovf %b expected 4 0",
               fifo_level, overflow);
    end
    fill_word(4'h5);
    checks++;
    if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL drop: got level %0d ovf %b expected 4 1",
               fifo_level, overflow);
    end
    checks++;
    if (word_out !== 32'h11111111) begin
      errors++;
      $display("FAIL drop_head: got %h expected 11111111", word_out);
    end
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr: got %b expected 0", overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q [4];
    exp_q[0] = 32'h22222222;
    exp_q[1] = 32'h33333333;
    exp_q[2] = 32'h44444444;
    exp_q[3] = 32'h66666666;
    for (int i = 0; i < 7; i++) nib(4'h6, 1'b0);
    word_ready = 1'b1;
    nib(4'h6, 1'b0);
    word_ready = 1'b0;
    checks++;
    if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL pushpop_full: got level %0d ovf %b expected 4 0",
               fifo_level, overflow);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (word_out !== exp_q[i] || word_valid !== 1'b1) begin
        errors++;
        $display("FAIL drain_%0d: got %h v=%b expected %h v=1",
                 i, word_out, word_valid, exp_q[i]);
      end
      pop_one();
    end
    checks++;
    if (fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL drain_empty: got %0d expected 0", fifo_level);
    end
  endtask

  task automatic test_flush_complete();
    nib(4'hF, 1'b0);
    nib(4'hE, 1'b0);
    nib(4'hD, 1'b0);
    nib(4'hC, 1'b0);
    nib(4'hB, 1'b0);
    nib(4'hA, 1'b0);
    nib(4'h9, 1'b0);
    nib(4'h8, 1'b1);
    checks++;
    if (word_out !== 32'h89ABCDEF || word_partial !== 1'b0) begin
      errors++;
      $display("FAIL flushfull_data: got %h p=%b expected 89abcdef p=0",
               word_out, word_partial);
    end
    step();
    checks++;
    if (fifo_level !== 3'd1) begin
      errors++;
      $display("FAIL flushfull_level: got %0d expected 1", fifo_level);
    end
    pop_one();
  endtask

  task automatic test_async_reset();
    fill_word(4'h7);
    fill_word(4'h9);
    for (int i = 0; i < 5; i++) nib(4'hE, 1'b0);
    checks++;
    if (fifo_level !== 3'd2) begin
      errors++;
      $display("FAIL pre_reset_level: got %0d expected 2", fifo_level);
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (word_valid !== 1'b0 || fifo_level !== 3'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got v=%b level %0d ovf %b expected 0 0 0",
               word_valid, fifo_level, overflow);
    end
    @(negedge clk);
    resetn = 1'b1;
    step();
    for (int i = 1; i <= 8; i++) nib(4'(i), 1'b0);
    checks++;
    if (word_out !== 32'h87654321 || word_partial !== 1'b0 ||
        fifo_level !== 3'd1) begin
      errors++;
      $display("FAIL post_reset_word: got %h p=%b level %0d expected 87654321 0 1",
               word_out, word_partial, fifo_level);
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_flush();
    test_overflow();
    test_back_to_back();
    test_flush_complete();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
